// File: rtl/cselsub_pkg.sv
// ----------------------------------------------------------------------------
// cselsub_pkg
// Shared constants and types for the pipelined carry-select subtractor.
//   WIDTH_DEFAULT / HALF_DEFAULT : default operand width and half width
//   result_t                     : {diff, no_borrow, ovf, zero} result bundle
//   SAT_POS / SAT_NEG            : saturation limits at the default width
// ----------------------------------------------------------------------------
package cselsub_pkg;

   localparam int WIDTH_DEFAULT = 32;
   localparam int HALF_DEFAULT  = WIDTH_DEFAULT / 2;

   typedef struct packed {
      logic [WIDTH_DEFAULT-1:0] diff;
      logic                     no_borrow;
      logic                     ovf;
      logic                     zero;
   } result_t;

   localparam logic [WIDTH_DEFAULT-1:0] SAT_POS = {1'b0, {(WIDTH_DEFAULT-1){1'b1}}};
   localparam logic [WIDTH_DEFAULT-1:0] SAT_NEG = {1'b1, {(WIDTH_DEFAULT-1){1'b0}}};

endpackage

// File: rtl/csel_half_add.sv
// ----------------------------------------------------------------------------
// csel_half_add
// Plain W-bit adder with carry-in and carry-out, used as the building block
// for the low half and both speculative high halves of the subtractor.
//   a, b  in  W   addends
//   cin   in  1   carry-in
//   sum   out W   a + b + cin (mod 2^W)
//   cout  out 1   carry-out
// ----------------------------------------------------------------------------
module csel_half_add #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/cselsub_pipe.sv
// ----------------------------------------------------------------------------
// cselsub_pipe
// Two-stage pipelined carry-select subtractor: diff = a - b = a + ~b + 1.
// Stage 1 registers the low-half sum and carry plus the raw high operands;
// stage 2 computes the high half for both carry-ins, selects with the
// registered low carry and registers the result and flags.
// Optional build macro: CSELSUB_SAT_EN -- saturate diff on signed overflow.
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      a/b valid
//   in_ready   out  1      a/b accepted this cycle when in_valid
//   a, b       in   WIDTH  minuend, subtrahend
//   out_valid  out  1      result fields valid
//   out_ready  in   1      consumer takes the result this cycle
//   diff       out  WIDTH  a - b (wrapped, or saturated with CSELSUB_SAT_EN)
//   no_borrow  out  1      1 when a >= b unsigned
//   ovf        out  1      signed overflow of a - b
//   zero       out  1      diff == 0
// ----------------------------------------------------------------------------
module cselsub_pipe
   import cselsub_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             no_borrow,
   output logic             ovf,
   output logic             zero
);

   localparam int HALF = WIDTH / 2;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic s1_valid_reg;
   logic s2_valid_reg;
   logic s2_load;
   logic s1_load;

   assign s2_load  = !s2_valid_reg || out_ready;
   assign in_ready = !s1_valid_reg || s2_load;
   assign s1_load  = in_valid && in_ready;

   // ------------------------------------------------------------------
   // Stage 1: low half of a + ~b + 1
   // ------------------------------------------------------------------
   logic [HALF-1:0] b_lo_inv;
   logic [HALF-1:0] lo_sum;
   logic            lo_cout;

   assign b_lo_inv = ~b[HALF-1:0];

   csel_half_add #(.W(HALF)) u_lo (
      .a    (a[HALF-1:0]),
      .b    (b_lo_inv),
      .cin  (1'b1),
      .sum  (lo_sum),
      .cout (lo_cout)
   );

   logic [HALF-1:0] lo_reg;
   logic            c_lo_reg;
   logic [HALF-1:0] a_hi_reg;
   logic [HALF-1:0] b_hi_inv_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         lo_reg       <= '0;
         c_lo_reg     <= 1'b0;
         a_hi_reg     <= '0;
         b_hi_inv_reg <= '0;
      end else if (in_ready) begin
         // An empty-or-draining stage 1 follows in_valid; data only on accept.
         s1_valid_reg <= in_valid;
         if (s1_load) begin
            lo_reg       <= lo_sum;
            c_lo_reg     <= lo_cout;
            a_hi_reg     <= a[WIDTH-1:HALF];
            b_hi_inv_reg <= ~b[WIDTH-1:HALF];
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: speculative high halves for carry-in 0 and 1
   // ------------------------------------------------------------------
   logic [HALF-1:0] hi_sum  [2];
   logic            hi_cout [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_hi
      csel_half_add #(.W(HALF)) u_hi (
         .a    (a_hi_reg),
         .b    (b_hi_inv_reg),
         .cin  ((gi == 1) ? 1'b1 : 1'b0),
         .sum  (hi_sum[gi]),
         .cout (hi_cout[gi])
      );
   end

   logic [HALF-1:0]  hi_sel;
   logic             carry_sel;
   logic [WIDTH-1:0] raw_diff;
   logic             a_msb;
   logic             b_msb;
   logic             ovf_next;
   logic [WIDTH-1:0] diff_next;
   logic             zero_next;

   assign hi_sel    = c_lo_reg ? hi_sum[1]  : hi_sum[0];
   assign carry_sel = c_lo_reg ? hi_cout[1] : hi_cout[0];
   assign raw_diff  = {hi_sel, lo_reg};
   assign a_msb     = a_hi_reg[HALF-1];
   assign b_msb     = ~b_hi_inv_reg[HALF-1];

   // Overflow only possible when operand signs differ; then the result
   // must carry the sign of the minuend.
   assign ovf_next  = (a_msb != b_msb) && (raw_diff[WIDTH-1] != a_msb);

`ifdef CSELSUB_SAT_EN
   localparam logic [WIDTH-1:0] SAT_HI = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_LO = {1'b1, {(WIDTH-1){1'b0}}};

   assign diff_next = ovf_next ? (a_msb ? SAT_LO : SAT_HI) : raw_diff;
`else
   assign diff_next = raw_diff;
`endif

   assign zero_next = (diff_next == '0);

   logic [WIDTH-1:0] diff_reg;
   logic             no_borrow_reg;
   logic             ovf_reg;
   logic             zero_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_reg  <= 1'b0;
         diff_reg      <= '0;
         no_borrow_reg <= 1'b0;
         ovf_reg       <= 1'b0;
         zero_reg      <= 1'b0;
      end else if (s2_load) begin
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            diff_reg      <= diff_next;
            no_borrow_reg <= carry_sel;
            ovf_reg       <= ovf_next;
            zero_reg      <= zero_next;
         end
      end
   end

   assign out_valid = s2_valid_reg;
   assign diff      = diff_reg;
   assign no_borrow = no_borrow_reg;
   assign ovf       = ovf_reg;
   assign zero      = zero_reg;

endmodule

// File: tb/tb_cselsub_pipe.sv
// ----------------------------------------------------------------------------
// tb_cselsub_pipe
// Directed and randomised handshake checks for cselsub_pipe (WIDTH=32).
// Expected results are {diff, no_borrow, ovf, zero} packed into 35 bits.
// ----------------------------------------------------------------------------
module tb_cselsub_pipe;
   import cselsub_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] diff;
   logic        no_borrow;
   logic        ovf;
   logic        zero;

   cselsub_pipe #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .no_borrow (no_borrow),
      .ovf       (ovf),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [34:0] obs;
   assign obs = {diff, no_borrow, ovf, zero};

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [34:0] exp_q [$];
   logic        hold_pending = 1'b0;
   logic [34:0] held = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, want);
   endtask

   // Arithmetic reference: full-width a + ~b + 1.
   function automatic logic [34:0] model(input logic [31:0] av, input logic [31:0] bv);
      logic [32:0] full;
      logic [31:0] d;
      logic        v;
      full = {1'b0, av} + {1'b0, ~bv} + 33'd1;
      v    = (av[31] != bv[31]) && (full[31] != av[31]);
      d    = full[31:0];
`ifdef CSELSUB_SAT_EN
      if (v) d = av[31] ? SAT_NEG : SAT_POS;
`endif
      return {d, full[32], v, (d == 32'd0)};
   endfunction

   // One clock cycle: drive at negedge, sample 1 time unit later, score the
   // handshakes that will fire on the following posedge.
   task automatic cycle(input logic iv, input logic [31:0] av, input logic [31:0] bv,
                        input logic ordy, input logic [34:0] expv);
      @(negedge clk);
      in_valid  = iv;
      a         = av;
      b         = bv;
      out_ready = ordy;
      #1;
      check("in_ready", {63'd0, in_ready}, {63'd0, !(exp_q.size() == 2 && !ordy)});
      if (hold_pending) begin
         check("hold_valid", {63'd0, out_valid}, 64'd1);
         check("hold_data", {29'd0, obs}, {29'd0, held});
      end
      if (out_valid && ordy) begin
         if (exp_q.size() == 0) begin
            check("spurious_out", {63'd0, out_valid}, 64'd0);
         end else begin
            logic [34:0] e;
            e = exp_q.pop_front();
            $display("out diff=%08h nb=%0d ovf=%0d z=%0d exp=%09h", diff, no_borrow, ovf, zero, e);
            check("result", {29'd0, obs}, {29'd0, e});
         end
      end
      hold_pending = out_valid && !ordy;
      held         = obs;
      if (iv && in_ready) exp_q.push_back(expv);
   endtask

   task automatic drain();
      for (int k = 0; k < 12 && exp_q.size() != 0; k++) cycle(1'b0, 32'd0, 32'd0, 1'b1, '0);
      check("drained", exp_q.size(), 64'd0);
   endtask

   task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic [34:0] expv);
      cycle(1'b1, av, bv, 1'b1, expv);
   endtask

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      #2 rst_n  = 1'b0;
      #1;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_outputs", {29'd0, obs}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Latency: accept, then s1 only, then output.
      send(32'h0000_0005, 32'h0000_0003, {32'h0000_0002, 1'b1, 1'b0, 1'b0});
      cycle(1'b0, 32'd0, 32'd0, 1'b1, '0);
      check("lat_stage1", {63'd0, out_valid}, 64'd0);
      cycle(1'b0, 32'd0, 32'd0, 1'b1, '0);
      check("lat_stage2", exp_q.size(), 64'd0);
      drain();

      // Directed boundaries.
      send(32'h0001_0000, 32'h0000_0001, {32'h0000_FFFF, 1'b1, 1'b0, 1'b0});
      send(32'h0000_0000, 32'h0000_0001, {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
      send(32'h1234_5678, 32'h1234_5678, {32'h0000_0000, 1'b1, 1'b0, 1'b1});
      send(32'h0002_0005, 32'h0001_0003, {32'h0001_0002, 1'b1, 1'b0, 1'b0});
      send(32'h0000_0005, 32'h0001_0003, {32'hFFFF_0002, 1'b0, 1'b0, 1'b0});
`ifdef CSELSUB_SAT_EN
      send(32'h8000_0000, 32'h0000_0001, {32'h8000_0000, 1'b1, 1'b1, 1'b0});
      send(32'h7FFF_FFFF, 32'hFFFF_FFFF, {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
`else
      send(32'h8000_0000, 32'h0000_0001, {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
      send(32'h7FFF_FFFF, 32'hFFFF_FFFF, {32'h8000_0000, 1'b0, 1'b1, 1'b0});
`endif
      drain();

      // Reset with both stages full and stalled.
      cycle(1'b1, 32'h0000_0009, 32'h0000_0004, 1'b0, {32'h5, 1'b1, 1'b0, 1'b0});
      cycle(1'b1, 32'h0000_0008, 32'h0000_0004, 1'b0, {32'h4, 1'b1, 1'b0, 1'b0});
      cycle(1'b1, 32'h0000_0007, 32'h0000_0004, 1'b0, {32'h3, 1'b1, 1'b0, 1'b0});
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      check("midrst_outputs", {29'd0, obs}, 64'd0);
      exp_q.delete();
      hold_pending = 1'b0;
      in_valid     = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 32'd0, 32'd0, 1'b1, '0);
         check("midrst_no_output", {63'd0, out_valid}, 64'd0);
      end

      // Streaming: full throughput, results in order.
      for (int i = 0; i < 100; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = $urandom;
         cycle(1'b1, ra, rb, 1'b1, model(ra, rb));
         if (i >= 2) check("stream_valid", {63'd0, out_valid}, 64'd1);
      end
      drain();

      // Random valid/ready on both sides.
      for (int i = 0; i < 300; i++) begin
         logic [31:0] ra, rb;
         logic        iv, ordy;
         ra   = $urandom;
         rb   = (i % 7 == 0) ? ra : $urandom;
         iv   = ($urandom_range(0, 1) == 1);
         ordy = ($urandom_range(0, 1) == 1);
         cycle(iv, ra, rb, ordy, model(ra, rb));
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
